// File: rtl/cr_prefix_fe_ctrl_pkg.sv
// Shared types and constants for the prefix feature-extractor front-end sequencer.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif

package cr_prefixPKG;

  typedef enum logic [2:0] {IDLE, RELOAD, FEED, SKIP, HOLD} fe_ctrl_st_e;

  localparam int unsigned FE_N_BLK     = 4;
  localparam int unsigned FE_BLK_BEATS = 8;

endpackage

// File: rtl/cr_prefix_fe_ctrl.sv
// Sequences one ingress frame into the fe counter banks: clear, feed 4 blocks, drop the rest,
// then hold the snapshot until the consumer acknowledges it.
module cr_prefix_fe_ctrl
  import cr_prefixPKG::*;
#(
  parameter int unsigned BLK_BEATS = FE_BLK_BEATS,
  parameter int unsigned N_BLK     = FE_N_BLK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [`AXI_S_DP_DWIDTH-1:0] s_tdata,
  input  logic [7:0]                  s_tstrb,
  input  logic                        s_tlast,
  output logic [`AXI_S_DP_DWIDTH-1:0] ibc_data_tlv_tdata,
  output logic [7:0]                  ibc_data_vbytes,
  output logic [1:0]                  ibc_blk_sel,
  output logic                        ibc_ctr_reload,
  output logic                        fe_done,
  output logic [2:0]                  fe_nblk,
  input  logic                        fe_ack
);

  fe_ctrl_st_e state_q, state_d;

  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic [1:0]                  blk_cnt_q, blk_cnt_d;
  logic [`AXI_S_DP_DWIDTH-1:0] tdata_q, tdata_d;
  logic [7:0]                  vbytes_q, vbytes_d;
  logic [1:0]                  blk_sel_q, blk_sel_d;
  logic                        done_pend_q, done_pend_d;
  logic                        fe_done_q, fe_done_d;
  logic [2:0]                  fe_nblk_q, fe_nblk_d;

  logic hs, beat_last, blk_last, ack_ok;

  assign hs        = s_tvalid & s_tready;
  assign beat_last = (beat_cnt_q == 8'(BLK_BEATS - 1));
  assign blk_last  = (blk_cnt_q == 2'(N_BLK - 1));
  // fe_done trails HOLD entry by a cycle so the last fed beat is already counted; acks
  // arriving before fe_done are not honoured.
  assign ack_ok    = fe_ack & ~done_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (s_tvalid) state_d = RELOAD;
      RELOAD: state_d = FEED;
      FEED: begin
        if (hs) begin
          if (s_tlast)                    state_d = HOLD;
          else if (beat_last && blk_last) state_d = SKIP;
        end
      end
      SKIP:   if (hs && s_tlast) state_d = HOLD;
      HOLD:   if (ack_ok) state_d = s_tvalid ? RELOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_tready       = (state_q == FEED) || (state_q == SKIP);
    ibc_ctr_reload = (state_q == RELOAD);
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    tdata_d     = tdata_q;
    vbytes_d    = '0;
    blk_sel_d   = blk_sel_q;
    done_pend_d = done_pend_q;
    fe_done_d   = 1'b0;
    fe_nblk_d   = fe_nblk_q;
    unique case (state_q)
      RELOAD: begin
        beat_cnt_d = '0;
        blk_cnt_d  = '0;
        fe_nblk_d  = '0;
      end
      FEED: begin
        if (hs) begin
          tdata_d   = s_tdata;
          vbytes_d  = s_tstrb;
          blk_sel_d = blk_cnt_q;
          if (beat_last) begin
            beat_cnt_d = '0;
            blk_cnt_d  = blk_cnt_q + 2'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
          if (s_tlast) begin
            fe_nblk_d   = {1'b0, blk_cnt_q} + 3'd1;
            done_pend_d = 1'b1;
          end
        end
      end
      SKIP: begin
        if (hs && s_tlast) begin
          fe_nblk_d   = 3'(N_BLK);
          done_pend_d = 1'b1;
        end
      end
      HOLD: begin
        if (done_pend_q) begin
          fe_done_d   = 1'b1;
          done_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      tdata_q     <= '0;
      vbytes_q    <= '0;
      blk_sel_q   <= '0;
      done_pend_q <= 1'b0;
      fe_done_q   <= 1'b0;
      fe_nblk_q   <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      tdata_q     <= tdata_d;
      vbytes_q    <= vbytes_d;
      blk_sel_q   <= blk_sel_d;
      done_pend_q <= done_pend_d;
      fe_done_q   <= fe_done_d;
      fe_nblk_q   <= fe_nblk_d;
    end
  end

  assign ibc_data_tlv_tdata = tdata_q;
  assign ibc_data_vbytes    = vbytes_q;
  assign ibc_blk_sel        = blk_sel_q;
  assign fe_done            = fe_done_q;
  assign fe_nblk            = fe_nblk_q;

endmodule

// File: tb/tb_cr_prefix_fe_ctrl.sv
// Scoreboard bench for cr_prefix_fe_ctrl: fed beats and frame-done events are predicted at
// the handshake and matched against the ibc_* / fe_* outputs by cycle.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif

module tb_cr_prefix_fe_ctrl;

  localparam int unsigned BB = 8;
  localparam int unsigned DW = `AXI_S_DP_DWIDTH;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [7:0]    s_tstrb;
  logic          s_tlast;
  logic [DW-1:0] ibc_data_tlv_tdata;
  logic [7:0]    ibc_data_vbytes;
  logic [1:0]    ibc_blk_sel;
  logic          ibc_ctr_reload;
  logic          fe_done;
  logic [2:0]    fe_nblk;
  logic          fe_ack;

  cr_prefix_fe_ctrl #(
    .BLK_BEATS (BB),
    .N_BLK     (4)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_tvalid           (s_tvalid),
    .s_tready           (s_tready),
    .s_tdata            (s_tdata),
    .s_tstrb            (s_tstrb),
    .s_tlast            (s_tlast),
    .ibc_data_tlv_tdata (ibc_data_tlv_tdata),
    .ibc_data_vbytes    (ibc_data_vbytes),
    .ibc_blk_sel        (ibc_blk_sel),
    .ibc_ctr_reload     (ibc_ctr_reload),
    .fe_done            (fe_done),
    .fe_nblk            (fe_nblk),
    .fe_ack             (fe_ack)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic [7:0]    strb;
    logic [1:0]    sel;
  } beat_exp_t;

  typedef struct {
    int         due;
    logic [2:0] nblk;
  } done_exp_t;

  beat_exp_t beat_q[$];
  done_exp_t done_q[$];

  int n_tests  = 0;
  int n_errors = 0;
  int cyc      = 0;
  int reload_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every cycle either a predicted beat/done is due, or the lane mask and
  // done pulse must be idle.
  always @(negedge clk) begin
    beat_exp_t b;
    done_exp_t d;
    while (beat_q.size() > 0 && beat_q[0].due < cyc) begin
      b = beat_q.pop_front();
      check_eq("beat_late", 64'(cyc), 64'(b.due));
    end
    if (beat_q.size() > 0 && beat_q[0].due == cyc) begin
      b = beat_q.pop_front();
      check_eq("tdata", ibc_data_tlv_tdata, b.data);
      check_eq("vbytes", 64'(ibc_data_vbytes), 64'(b.strb));
      check_eq("blk_sel", 64'(ibc_blk_sel), 64'(b.sel));
    end else begin
      check_eq("idle_vbytes", 64'(ibc_data_vbytes), 64'd0);
    end
    if (done_q.size() > 0 && done_q[0].due == cyc) begin
      d = done_q.pop_front();
      check_eq("fe_done", 64'(fe_done), 64'd1);
      check_eq("fe_nblk", 64'(fe_nblk), 64'(d.nblk));
    end else begin
      check_eq("no_fe_done", 64'(fe_done), 64'd0);
    end
    if (ibc_ctr_reload) reload_cnt++;
  end

  // Sends one frame starting at a negedge; returns at the negedge after the last handshake.
  task automatic send_frame(input int nbeats, input int gap_pct, input logic rnd_strb,
                            input logic [7:0] last_strb, input int abort_at);
    int guard;
    int r0;
    logic [7:0] strb;
    beat_exp_t b;
    done_exp_t d;
    r0 = reload_cnt;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_at) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        return;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(negedge clk);
      end
      strb = rnd_strb ? 8'($urandom_range(255)) : 8'hFF;
      if (i == nbeats - 1) strb = last_strb;
      s_tvalid = 1'b1;
      s_tdata  = {$urandom(), $urandom()};
      s_tstrb  = strb;
      s_tlast  = (i == nbeats - 1);
      guard = 0;
      while (!s_tready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!s_tready) begin
        check_eq("tready_timeout", 64'(guard), 64'd0);
        s_tvalid = 1'b0;
        return;
      end
      if (i < 4 * BB) begin
        b.due  = cyc + 1;
        b.data = s_tdata;
        b.strb = strb;
        b.sel  = 2'(i / BB);
        beat_q.push_back(b);
      end
      if (i == nbeats - 1) begin
        d.due  = cyc + 2;
        d.nblk = (i < 4 * BB) ? 3'(i / BB + 1) : 3'd4;
        done_q.push_back(d);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_eq("reload_pulses", 64'(reload_cnt - r0), 64'd1);
  endtask

  task automatic ack_after(input int dly);
    int guard;
    logic exp_rl;
    guard = 0;
    while (!fe_done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_seen", 64'(fe_done), 64'd1);
    for (int k = 0; k < dly; k++) begin
      check_eq("hold_tready", 64'(s_tready), 64'd0);
      @(negedge clk);
    end
    check_eq("hold_tready", 64'(s_tready), 64'd0);
    exp_rl = s_tvalid;
    fe_ack = 1'b1;
    @(negedge clk);
    fe_ack = 1'b0;
    check_eq("reload_after_ack", 64'(ibc_ctr_reload), 64'(exp_rl));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tready"}, 64'(s_tready), 64'd0);
    check_eq({tag, "_tdata"}, ibc_data_tlv_tdata, 64'd0);
    check_eq({tag, "_blk_sel"}, 64'(ibc_blk_sel), 64'd0);
    check_eq({tag, "_reload"}, 64'(ibc_ctr_reload), 64'd0);
    check_eq({tag, "_nblk"}, 64'(fe_nblk), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    fe_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 40 beats: four blocks fed, last 8 dropped in SKIP
    send_frame(40, 0, 1'b0, 8'hFF, -1);
    ack_after(2);
    @(negedge clk);

    // 11 beats ending mid block 1 with a partial strobe
    send_frame(11, 0, 1'b0, 8'h0F, -1);
    ack_after(1);
    @(negedge clk);

    // exactly four blocks, tlast on the final beat of block 3
    send_frame(32, 0, 1'b0, 8'hFF, -1);
    // next frame presented during HOLD; ack 5 cycles after fe_done
    fork
      ack_after(5);
      send_frame(20, 0, 1'b0, 8'h3C, -1);
    join
    ack_after(0);
    @(negedge clk);

    // ingress bubbles and random strobes, including zero-strobe beats
    send_frame(28, 50, 1'b1, 8'hA5, -1);
    ack_after(3);
    @(negedge clk);

    // reset mid-frame, then a fresh frame
    send_frame(30, 0, 1'b0, 8'hFF, 13);
    repeat (3) begin
      @(negedge clk);
      check_all_zero("midreset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(12, 0, 1'b0, 8'h81, -1);
    ack_after(2);

    repeat (4) @(negedge clk);
    check_eq("beat_q_drained", 64'(beat_q.size()), 64'd0);
    check_eq("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_errors);
    $finish;
  end

endmodule
